submem_loader: RTL and testbench
================================

Name: submem_loader

Overview:
- Main-core-side engine that drives the other end of a subcore data-memory interface.
- Writes go in through the subcore's main-write ports (u/l lanes, one data_in each).
- Readback uses the subcore fetch path: assert the subcore interlock, drive fetch_addr, capture fetch_result.
- The main core issues block WRITE/READ commands; data streams through valid/ready channels.

Parameters:
- ADDR_W, 17, word-address width of the subcore data memory; addresses wrap modulo 2^ADDR_W.
- LEN_W, 16, width of the command length field, in words.
- FETCH_LAT, 3, cycles from driving sub_fetch_addr to a valid sub_fetch_result.
- RD_FIFO_DEPTH, 4, read-return FIFO entries; must be >= FETCH_LAT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_op  in  1  0=WRITE, 1=READ
- cmd_base  in  ADDR_W  first word address
- cmd_len  in  LEN_W  word count
- wr_valid  in  1  write beat offered
- wr_ready  out  1  write beat taken
- wr_data  in  64  [31:0] lower word (u lane), [63:32] upper word (l lane)
- rd_valid  out  1  read word available
- rd_ready  in  1  consumer takes word
- rd_data  out  32  read word
- done  out  1  one-cycle pulse when a command completes
- busy  out  1  high from acceptance to done
- sub_halted  in  1  subcore pipeline quiescent
- sub_interlock  out  1  to subcore interlock
- sub_fetch_addr  out  32  to subcore fetch_addr; zero-extended word address
- sub_fetch_result  in  32  from subcore fetch_result
- sub_u_wr  out  data_in  u-lane main write {addr, din, we}
- sub_l_wr  out  data_in  l-lane main write

Behaviour:
- Reset (synchronous, any state):
  - cmd_ready=1, busy=0, done=0, wr_ready=0, rd_valid=0, sub_interlock=0, sub_fetch_addr=0, both we=0.
  - FIFO and counters cleared.
  - A command in flight is abandoned; no further writes are issued.
- States: IDLE -> WAIT_HALT -> (WRITE | READ) -> DRAIN (READ only) -> DONE -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On handshake: latch op/base/len, busy=1, go to WAIT_HALT.
  - len==0 goes straight to DONE instead.
- WAIT_HALT: hold until sub_halted=1; no memory traffic.
- WRITE:
  - wr_ready=1 while remaining>0.
  - Each beat, registered next cycle: u.addr=base+2i, u.din=wr_data[31:0], u.we=1; l.addr=base+2i+1, l.din=wr_data[63:32], l.we=(remaining>=2).
  - we=0 on cycles without a beat.
  - Odd len: final beat writes the u lane only.
  - After the last beat, go to DONE.
- READ:
  - sub_interlock=1 from entry until DRAIN exits.
  - Issue one fetch per cycle: sub_fetch_addr=base+k, k=0..len-1.
  - Issue only when outstanding+fifo_count < RD_FIFO_DEPTH.
  - A word issued at cycle t is pushed to the FIFO at t+FETCH_LAT via a FETCH_LAT-deep valid shift register.
  - sub_fetch_addr holds its last value when not issuing; a stale result is never pushed.
  - After the last issue, go to DRAIN.
- DRAIN: wait until outstanding==0 and the FIFO is empty, then go to DONE. sub_interlock drops on the DONE cycle.
- rd channel:
  - rd_valid = FIFO non-empty; rd_data = FIFO head.
  - Pop on rd_valid&&rd_ready.
  - Simultaneous push and pop keep the count unchanged.
- DONE: done=1 for one cycle, busy=0, return to IDLE. cmd_ready=0 in every state except IDLE.
- Address arithmetic is ADDR_W bits and wraps: base=2^ADDR_W-1, len=2 touches the last word, then word 0.
- Subcore priority: the subcore gives main writes priority over its own writes; WAIT_HALT exists so that no collision occurs.

Optional Feature:
- Macro: SUBMEM_RD_CHECKSUM_EN.
- When defined:
  - Adds output rd_csum[31:0], the 32-bit wrapping sum of every word pushed to the FIFO during the current READ.
  - Cleared on command acceptance; valid on the done cycle; holds until the next acceptance.
  - Reset value 0.
- When undefined: port and adder are absent; behaviour is otherwise identical.

Decomposition:
- inst_package holds:
  - the data_in typedef;
  - DATA_MEM_DEPTH;
  - a new enum submem_state_t {IDLE, WAIT_HALT, WRITE, READ, DRAIN, DONE};
  - localparams SUBMEM_OP_WRITE=0 and SUBMEM_OP_READ=1.
- One sub-module: submem_rd_fifo (parameterised sync FIFO exposing count, push, pop, full, empty).

Test Plan:
- WRITE, base=0x10, len=4, beats 0x22221111_11111111 then 0x44444444_33333333, sub_halted=1:
  - u writes 0x10/0x11111111 and 0x12/0x33333333;
  - l writes 0x11/0x22221111 and 0x13/0x44444444;
  - one done pulse.
- WRITE, len=3: second beat has l.we=0; exactly 3 words are written.
- READ, base=0x100, len=6, model returns mem[a]=a*3 after FETCH_LAT, rd_ready=1:
  - rd_data sequence 0x300, 0x303, ..., 0x30F;
  - sub_interlock is high throughout and low after done.
- READ, len=8, rd_ready=0 for 20 cycles:
  - issues stop after 4 outstanding/occupied; no word lost or duplicated;
  - resumes on rd_ready=1.
- Command with sub_halted=0 for 10 cycles: no we and no interlock until sub_halted rises. len=0 command: done pulses the cycle after acceptance.
- rst asserted mid-READ at word 3: the next cycle has all outputs at reset values and FIFO empty. A fresh command then completes normally (with SUBMEM_RD_CHECKSUM_EN, rd_csum equals the sum of the fresh words only).

Source files
------------

// File: rtl/submem_loader_pkg.sv
// submem_loader_pkg
//   Shared types for the subcore data-memory loader.
//   - data_in        : one main-write lane into the subcore {addr, din, we}
//   - submem_state_t : loader FSM states
//   - SUBMEM_OP_*    : cmd_op encodings
package submem_loader_pkg;

  localparam int DMEM_ADDR_W    = 17;
  localparam int DATA_MEM_DEPTH = 1 << DMEM_ADDR_W;

  localparam logic SUBMEM_OP_WRITE = 1'b0;
  localparam logic SUBMEM_OP_READ  = 1'b1;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] addr;
    logic [31:0]            din;
    logic                   we;
  } data_in;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HALT,
    WRITE,
    READ,
    DRAIN,
    DONE
  } submem_state_t;

endpackage

// File: rtl/submem_loader_rd_fifo.sv
// submem_rd_fifo
//   Synchronous FIFO holding fetched words until the read consumer takes them.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     push, din     write side (ignored when full)
//     pop, dout     read side, dout is the head word (ignored when empty)
//     count         current occupancy
//     full, empty   occupancy flags
module submem_rd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/submem_loader.sv
// submem_loader
//   Main-core-side engine for a subcore data memory. Block WRITEs go out
//   through the subcore main-write lanes (u = even word, l = odd word);
//   block READs hold the subcore interlock and walk its fetch port.
//   Ports:
//     clk, rst                          clock, synchronous active-high reset
//     cmd_valid/ready, cmd_op/base/len  block command (op 0=WRITE, 1=READ)
//     wr_valid/ready, wr_data           write beats, two words per beat
//     rd_valid/ready, rd_data           read words, one per handshake
//     done, busy                        completion pulse, command in flight
//     sub_halted                        subcore pipeline quiescent
//     sub_interlock                     stalls the subcore during READ
//     sub_fetch_addr/result             subcore fetch port
//     sub_u_wr, sub_l_wr                subcore main-write lanes
//   Optional: SUBMEM_RD_CHECKSUM_EN adds rd_csum, the wrapping sum of the
//   words returned by the current READ.
//
//   state     | meaning
//   IDLE      | cmd_ready, waiting for a command
//   WAIT_HALT | command latched, waiting for the subcore to go quiescent
//   WRITE     | taking write beats, one lane pair per beat
//   READ      | issuing fetches, throttled by FIFO credit
//   DRAIN     | all fetches issued, waiting for returns and FIFO to empty
//   DONE      | one-cycle done pulse
module submem_loader
  import submem_loader_pkg::*;
#(
  parameter int ADDR_W        = $clog2(DATA_MEM_DEPTH),
  parameter int LEN_W         = 16,
  parameter int FETCH_LAT     = 3,
  parameter int RD_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [63:0]       wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       rd_data,
  output logic              done,
  output logic              busy,
  input  logic              sub_halted,
  output logic              sub_interlock,
  output logic [31:0]       sub_fetch_addr,
  input  logic [31:0]       sub_fetch_result,
`ifdef SUBMEM_RD_CHECKSUM_EN
  output logic [31:0]       rd_csum,
`endif
  output data_in            sub_u_wr,
  output data_in            sub_l_wr
);

  localparam int FCNT_W = $clog2(RD_FIFO_DEPTH + 1);
  localparam int OCNT_W = $clog2(FETCH_LAT + 1);

  submem_state_t        state_q, state_d;
  logic                 op_q, op_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic [ADDR_W-1:0]    fetch_addr_q, fetch_addr_d;
  logic [FETCH_LAT-1:0] pend_q, pend_d;
  logic [OCNT_W-1:0]    outst_q, outst_d;
  data_in               u_wr_q, u_wr_d;
  data_in               l_wr_q, l_wr_d;
`ifdef SUBMEM_RD_CHECKSUM_EN
  logic [31:0]          csum_q, csum_d;
`endif

  logic              issue;
  logic              push;
  logic              fifo_full, fifo_empty;
  logic [FCNT_W-1:0] fifo_count;

  submem_rd_fifo #(
    .DEPTH (RD_FIFO_DEPTH),
    .WIDTH (32)
  ) u_rd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (sub_fetch_result),
    .pop   (rd_ready),
    .dout  (rd_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A fetch result is valid FETCH_LAT cycles after its address is driven;
  // only slots that carried a real issue reach the FIFO.
  assign push = pend_q[FETCH_LAT-1];

  assign rd_valid       = !fifo_empty;
  assign cmd_ready      = (state_q == IDLE);
  assign done           = (state_q == DONE);
  assign busy           = (state_q != IDLE) && (state_q != DONE);
  assign sub_interlock  = (state_q == READ) || (state_q == DRAIN);
  assign sub_fetch_addr = 32'(issue ? addr_q : fetch_addr_q);
  assign sub_u_wr       = u_wr_q;
  assign sub_l_wr       = l_wr_q;
`ifdef SUBMEM_RD_CHECKSUM_EN
  assign rd_csum        = csum_q;
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    fetch_addr_d = fetch_addr_q;
    u_wr_d       = u_wr_q;
    u_wr_d.we    = 1'b0;
    l_wr_d       = l_wr_q;
    l_wr_d.we    = 1'b0;
    wr_ready     = 1'b0;
    // Credit counts in-flight fetches plus stored words, so the FIFO can
    // never be asked to take a word it has no room for.
    issue        = (state_q == READ) && (rem_q != '0) && !fifo_full &&
                   (int'(outst_q) + int'(fifo_count) < RD_FIFO_DEPTH);
    pend_d       = pend_q << 1;
    pend_d[0]    = issue;
    outst_d      = outst_q + OCNT_W'(issue) - OCNT_W'(push);
`ifdef SUBMEM_RD_CHECKSUM_EN
    csum_d       = push ? csum_q + sub_fetch_result : csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_base;
          rem_d   = cmd_len;
          state_d = (cmd_len == '0) ? DONE : WAIT_HALT;
`ifdef SUBMEM_RD_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      WAIT_HALT: begin
        if (sub_halted) begin
          state_d = (op_q == SUBMEM_OP_READ) ? READ : WRITE;
        end
      end
      WRITE: begin
        wr_ready = (rem_q != '0);
        if (wr_valid && wr_ready) begin
          u_wr_d.addr = addr_q;
          u_wr_d.din  = wr_data[31:0];
          u_wr_d.we   = 1'b1;
          l_wr_d.addr = addr_q + ADDR_W'(1);
          l_wr_d.din  = wr_data[63:32];
          l_wr_d.we   = (rem_q >= LEN_W'(2));
          addr_d      = addr_q + ADDR_W'(2);
          rem_d       = (rem_q >= LEN_W'(2)) ? rem_q - LEN_W'(2) : '0;
          if (rem_q <= LEN_W'(2)) begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        if (issue) begin
          fetch_addr_d = addr_q;
          addr_d       = addr_q + ADDR_W'(1);
          rem_d        = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((outst_q == '0) && fifo_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= SUBMEM_OP_WRITE;
      addr_q       <= '0;
      rem_q        <= '0;
      fetch_addr_q <= '0;
      pend_q       <= '0;
      outst_q      <= '0;
      u_wr_q       <= '0;
      l_wr_q       <= '0;
`ifdef SUBMEM_RD_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      fetch_addr_q <= fetch_addr_d;
      pend_q       <= pend_d;
      outst_q      <= outst_d;
      u_wr_q       <= u_wr_d;
      l_wr_q       <= l_wr_d;
`ifdef SUBMEM_RD_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_submem_loader.sv
module tb_submem_loader;
  import submem_loader_pkg::*;

  localparam int FL = 3;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [16:0] cmd_base;
  logic [15:0] cmd_len;
  logic        wr_valid, wr_ready;
  logic [63:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        done, busy;
  logic        sub_halted, sub_interlock;
  logic [31:0] sub_fetch_addr, sub_fetch_result;
  data_in      sub_u_wr, sub_l_wr;
`ifdef SUBMEM_RD_CHECKSUM_EN
  logic [31:0] rd_csum;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] u_a[$], l_a[$];
  logic [31:0] u_d[$], l_d[$], rq[$];
  int          done_cnt  = 0;
  int          issue_cnt = 0;
  logic [31:0] prev_fa   = '0;
  bit          il_seen, il_gap, il_at_done;
  logic [31:0] fpipe [FL];

  submem_loader dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_base         (cmd_base),
    .cmd_len          (cmd_len),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_data          (wr_data),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_data          (rd_data),
    .done             (done),
    .busy             (busy),
    .sub_halted       (sub_halted),
    .sub_interlock    (sub_interlock),
    .sub_fetch_addr   (sub_fetch_addr),
    .sub_fetch_result (sub_fetch_result),
`ifdef SUBMEM_RD_CHECKSUM_EN
    .rd_csum          (rd_csum),
`endif
    .sub_u_wr         (sub_u_wr),
    .sub_l_wr         (sub_l_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Subcore fetch model: mem[a] = a*3, result FL cycles after the address.
  always @(posedge clk) begin
    fpipe[0] <= sub_fetch_addr * 32'd3;
    for (int i = 1; i < FL; i++) fpipe[i] <= fpipe[i-1];
  end
  assign sub_fetch_result = fpipe[FL-1];

  always @(posedge clk) begin
    if (sub_u_wr.we) begin u_a.push_back(sub_u_wr.addr); u_d.push_back(sub_u_wr.din); end
    if (sub_l_wr.we) begin l_a.push_back(sub_l_wr.addr); l_d.push_back(sub_l_wr.din); end
    if (rd_valid && rd_ready) rq.push_back(rd_data);
    if (done) done_cnt++;
    if (sub_interlock && (sub_fetch_addr != prev_fa)) issue_cnt++;
    prev_fa = sub_fetch_addr;
  end

  task automatic clear_logs();
    u_a.delete(); u_d.delete(); l_a.delete(); l_d.delete(); rq.delete();
    done_cnt = 0; issue_cnt = 0;
  endtask

  task automatic send_cmd(input logic op, input logic [16:0] base, input logic [15:0] len,
                          output bit to);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len;
    to = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (cmd_ready) begin to = 1'b0; break; end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_beats(input logic [63:0] beats[4], input int nb, output bit to);
    to = 1'b0;
    for (int k = 0; k < nb; k++) begin
      bit taken = 1'b0;
      wr_valid = 1'b1; wr_data = beats[k];
      for (int n = 0; n < 100; n++) begin
        if (wr_ready) begin taken = 1'b1; break; end
        @(negedge clk);
      end
      if (!taken) to = 1'b1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit to);
    to = 1'b1; il_seen = 1'b0; il_gap = 1'b0; il_at_done = 1'b0;
    for (int n = 0; n < limit; n++) begin
      if (done) begin il_at_done = sub_interlock; to = 1'b0; break; end
      if (sub_interlock) il_seen = 1'b1;
      else if (il_seen) il_gap = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [7:0] got, exp;
    string nm [8] = '{"l_we", "u_we", "sub_interlock", "rd_valid", "wr_ready", "done", "busy", "cmd_ready"};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    got = {cmd_ready, busy, done, wr_ready, rd_valid, sub_interlock, sub_u_wr.we, sub_l_wr.we};
    exp = 8'b1000_0000;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin
        n_fail++; $display("FAIL reset_%s: got %b expected %b", nm[i], got[i], exp[i]);
      end
    end
    n_checks++;
    if (sub_fetch_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_fetch_addr: got %h expected 0", sub_fetch_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_even();
    logic [63:0] bt [4] = '{64'h22221111_11111111, 64'h44444444_33333333, 64'h0, 64'h0};
    logic [16:0] eua [2] = '{17'h10, 17'h12};
    logic [31:0] eud [2] = '{32'h11111111, 32'h33333333};
    logic [16:0] ela [2] = '{17'h11, 17'h13};
    logic [31:0] eld [2] = '{32'h22221111, 32'h44444444};
    bit to;
    clear_logs(); sub_halted = 1'b1;
    send_cmd(SUBMEM_OP_WRITE, 17'h10, 16'd4, to);
    send_beats(bt, 2, to);
    wait_done(50, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL wr4_done: got timeout expected done"); end
    @(negedge clk);
    n_checks++;
    if (u_a.size() !== 2 || l_a.size() !== 2) begin
      n_fail++; $display("FAIL wr4_count: got u=%0d l=%0d expected 2 2", u_a.size(), l_a.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (u_a[i] !== eua[i] || u_d[i] !== eud[i]) begin
          n_fail++; $display("FAIL wr4_u%0d: got %h/%h expected %h/%h", i, u_a[i], u_d[i], eua[i], eud[i]);
        end
        n_checks++;
        if (l_a[i] !== ela[i] || l_d[i] !== eld[i]) begin
          n_fail++; $display("FAIL wr4_l%0d: got %h/%h expected %h/%h", i, l_a[i], l_d[i], ela[i], eld[i]);
        end
      end
    end
    n_checks++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL wr4_pulse: got %0d done cycles expected 1", done_cnt); end
  endtask

  task automatic test_write_odd();
    logic [63:0] bt [4] = '{64'hBBBB0002_AAAA0001, 64'hDDDD0004_CCCC0003, 64'h0, 64'h0};
    bit to;
    clear_logs();
    send_cmd(SUBMEM_OP_WRITE, 17'h20, 16'd3, to);
    send_beats(bt, 2, to);
    wait_done(50, to);
    @(negedge clk);
    n_checks++;
    if (u_a.size() !== 2 || l_a.size() !== 1) begin
      n_fail++; $display("FAIL wr3_count: got u=%0d l=%0d expected 2 1", u_a.size(), l_a.size());
    end else begin
      n_checks++;
      if (u_a[0] !== 17'h20 || u_d[0] !== 32'hAAAA0001) begin
        n_fail++; $display("FAIL wr3_u0: got %h/%h expected 20/aaaa0001", u_a[0], u_d[0]);
      end
      n_checks++;
      if (l_a[0] !== 17'h21 || l_d[0] !== 32'hBBBB0002) begin
        n_fail++; $display("FAIL wr3_l0: got %h/%h expected 21/bbbb0002", l_a[0], l_d[0]);
      end
      n_checks++;
      if (u_a[1] !== 17'h22 || u_d[1] !== 32'hCCCC0003) begin
        n_fail++; $display("FAIL wr3_u1: got %h/%h expected 22/cccc0003", u_a[1], u_d[1]);
      end
    end
  endtask

  task automatic test_read_stream();
    bit to;
    clear_logs(); rd_ready = 1'b1;
    send_cmd(SUBMEM_OP_READ, 17'h100, 16'd6, to);
    wait_done(100, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL rd6_done: got timeout expected done"); end
    n_checks++;
    if (!il_seen || il_gap || il_at_done) begin
      n_fail++; $display("FAIL rd6_interlock: got seen=%0d gap=%0d at_done=%0d expected 1 0 0", il_seen, il_gap, il_at_done);
    end
    @(negedge clk);
    n_checks++;
    if (sub_interlock !== 1'b0) begin n_fail++; $display("FAIL rd6_il_after: got %b expected 0", sub_interlock); end
    n_checks++;
    if (rq.size() !== 6) begin
      n_fail++; $display("FAIL rd6_count: got %0d expected 6", rq.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (rq[k] !== 32'h300 + 32'(3 * k)) begin
          n_fail++; $display("FAIL rd6_word%0d: got %h expected %h", k, rq[k], 32'h300 + 32'(3 * k));
        end
      end
    end
`ifdef SUBMEM_RD_CHECKSUM_EN
    n_checks++;
    if (rd_csum !== 32'h122D) begin n_fail++; $display("FAIL rd6_csum: got %h expected 122d", rd_csum); end
`endif
  endtask

  task automatic test_read_backpressure();
    bit to;
    clear_logs(); rd_ready = 1'b0;
    send_cmd(SUBMEM_OP_READ, 17'h200, 16'd8, to);
    repeat (20) @(negedge clk);
    n_checks++;
    if (issue_cnt !== 4) begin n_fail++; $display("FAIL bp_issued: got %0d expected 4", issue_cnt); end
    n_checks++;
    if (rd_valid !== 1'b1 || rq.size() !== 0) begin
      n_fail++; $display("FAIL bp_hold: got rd_valid=%b taken=%0d expected 1 0", rd_valid, rq.size());
    end
    rd_ready = 1'b1;
    wait_done(200, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL bp_done: got timeout expected done"); end
    @(negedge clk);
    n_checks++;
    if (rq.size() !== 8 || issue_cnt !== 8) begin
      n_fail++; $display("FAIL bp_count: got words=%0d issues=%0d expected 8 8", rq.size(), issue_cnt);
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (rq[k] !== 32'h600 + 32'(3 * k)) begin
          n_fail++; $display("FAIL bp_word%0d: got %h expected %h", k, rq[k], 32'h600 + 32'(3 * k));
        end
      end
    end
  endtask

  task automatic test_halt_wait();
    logic [63:0] bt [4] = '{64'hDEAD0002_BEEF0001, 64'h0, 64'h0, 64'h0};
    bit to;
    bit bad;
    clear_logs(); sub_halted = 1'b0; rd_ready = 1'b1;
    send_cmd(SUBMEM_OP_WRITE, 17'h30, 16'd2, to);
    wr_valid = 1'b1; wr_data = bt[0];
    bad = 1'b0;
    repeat (10) begin
      if (wr_ready || sub_interlock) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad || u_a.size() !== 0 || l_a.size() !== 0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL halt_wr_hold: got bad=%0d u=%0d l=%0d busy=%b expected 0 0 0 1", bad, u_a.size(), l_a.size(), busy);
    end
    sub_halted = 1'b1;
    send_beats(bt, 1, to);
    wait_done(50, to);
    @(negedge clk);
    n_checks++;
    if (u_a.size() !== 1 || l_a.size() !== 1) begin
      n_fail++; $display("FAIL halt_wr_count: got u=%0d l=%0d expected 1 1", u_a.size(), l_a.size());
    end else begin
      n_checks++;
      if (u_a[0] !== 17'h30 || u_d[0] !== 32'hBEEF0001 || l_a[0] !== 17'h31 || l_d[0] !== 32'hDEAD0002) begin
        n_fail++; $display("FAIL halt_wr_data: got %h/%h %h/%h expected 30/beef0001 31/dead0002", u_a[0], u_d[0], l_a[0], l_d[0]);
      end
    end
    clear_logs(); sub_halted = 1'b0;
    send_cmd(SUBMEM_OP_READ, 17'h60, 16'd1, to);
    bad = 1'b0;
    repeat (10) begin
      if (sub_interlock || rd_valid) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL halt_rd_hold: got interlock/rd_valid activity expected none"); end
    sub_halted = 1'b1;
    wait_done(50, to);
    @(negedge clk);
    n_checks++;
    if (rq.size() !== 1 || rq[0] !== 32'h120) begin
      n_fail++; $display("FAIL halt_rd_word: got n=%0d w=%h expected 1 120", rq.size(), rq.size() > 0 ? rq[0] : 32'h0);
    end
  endtask

  task automatic test_len_zero();
    bit to;
    clear_logs();
    send_cmd(SUBMEM_OP_WRITE, 17'h0, 16'd0, to);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL len0_done: got done=%b busy=%b cmd_ready=%b expected 1 0 0", done, busy, cmd_ready);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || u_a.size() !== 0) begin
      n_fail++; $display("FAIL len0_after: got done=%b cmd_ready=%b writes=%0d expected 0 1 0", done, cmd_ready, u_a.size());
    end
  endtask

  task automatic test_wrap();
    bit to;
    clear_logs(); rd_ready = 1'b1;
    send_cmd(SUBMEM_OP_READ, 17'h1FFFF, 16'd2, to);
    wait_done(100, to);
    @(negedge clk);
    n_checks++;
    if (rq.size() !== 2) begin
      n_fail++; $display("FAIL wrap_count: got %0d expected 2", rq.size());
    end else begin
      n_checks++;
      if (rq[0] !== 32'h5FFFD || rq[1] !== 32'h0) begin
        n_fail++; $display("FAIL wrap_words: got %h %h expected 5fffd 0", rq[0], rq[1]);
      end
    end
`ifdef SUBMEM_RD_CHECKSUM_EN
    n_checks++;
    if (rd_csum !== 32'h5FFFD) begin n_fail++; $display("FAIL wrap_csum: got %h expected 5fffd", rd_csum); end
`endif
  endtask

  task automatic test_reset_midread();
    bit to;
    bit hit;
    logic [7:0] got;
    clear_logs(); rd_ready = 1'b1;
    send_cmd(SUBMEM_OP_READ, 17'h400, 16'd8, to);
    hit = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (rq.size() >= 3) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL rstrd_reach: got %0d words expected 3", rq.size()); end
    rst = 1'b1;
    @(negedge clk);
    got = {cmd_ready, busy, done, wr_ready, rd_valid, sub_interlock, sub_u_wr.we, sub_l_wr.we};
    n_checks++;
    if (got !== 8'b1000_0000 || sub_fetch_addr !== 32'h0) begin
      n_fail++; $display("FAIL rstrd_outputs: got %b addr=%h expected 10000000 addr=0", got, sub_fetch_addr);
    end
    rst = 1'b0;
    clear_logs();
    repeat (8) @(negedge clk);
    n_checks++;
    if (rq.size() !== 0 || rd_valid !== 1'b0 || done_cnt !== 0) begin
      n_fail++; $display("FAIL rstrd_quiet: got words=%0d rd_valid=%b done=%0d expected 0 0 0", rq.size(), rd_valid, done_cnt);
    end
    send_cmd(SUBMEM_OP_READ, 17'h50, 16'd3, to);
    wait_done(100, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL rstrd_fresh_done: got timeout expected done"); end
    @(negedge clk);
    n_checks++;
    if (rq.size() !== 3) begin
      n_fail++; $display("FAIL rstrd_fresh_count: got %0d expected 3", rq.size());
    end else begin
      n_checks++;
      if (rq[0] !== 32'hF0 || rq[1] !== 32'hF3 || rq[2] !== 32'hF6) begin
        n_fail++; $display("FAIL rstrd_fresh_words: got %h %h %h expected f0 f3 f6", rq[0], rq[1], rq[2]);
      end
    end
`ifdef SUBMEM_RD_CHECKSUM_EN
    n_checks++;
    if (rd_csum !== 32'h2D9) begin n_fail++; $display("FAIL rstrd_csum: got %h expected 2d9", rd_csum); end
`endif
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; sub_halted = 1'b1;
    for (int i = 0; i < FL; i++) fpipe[i] = '0;
    test_reset();
    test_write_even();
    test_write_odd();
    test_read_stream();
    test_read_backpressure();
    test_halt_wait();
    test_len_zero();
    test_wrap();
    test_reset_midread();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
